// File: rtl/led_sequencer_if.sv
// LED sequencer pin bundle: tick and button inputs in, four LED drives out.
//   i_Tick      slow toggle from the clock divider (one step per level change)
//   i_Switch_1  raw mode push-button, active-high
//   o_LED_1..4  LED drives, o_LED_1 is pattern bit 0
interface led_sequencer_if;
  logic i_Tick;
  logic i_Switch_1;
  logic o_LED_1;
  logic o_LED_2;
  logic o_LED_3;
  logic o_LED_4;

  modport master (
    output i_Tick,
    output i_Switch_1,
    input  o_LED_1,
    input  o_LED_2,
    input  o_LED_3,
    input  o_LED_4
  );

  modport slave (
    input  i_Tick,
    input  i_Switch_1,
    output o_LED_1,
    output o_LED_2,
    output o_LED_3,
    output o_LED_4
  );
endinterface

// File: rtl/led_sequencer.sv
// Animated four-LED pattern generator.
//   i_Clk    25 MHz board clock, rising edge
//   i_Rst_n  asynchronous active-low reset
//   bus      tick/button inputs and LED outputs (led_sequencer_if.slave)
// Each level change of bus.i_Tick advances the pattern one step; a debounced
// press of bus.i_Switch_1 cycles CHASE -> BOUNCE -> BLINK -> COUNT -> CHASE.
module led_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic           i_Clk,
  input  logic           i_Rst_n,
  led_sequencer_if.slave bus
);

  localparam int unsigned CNT_W   = 24;
  localparam int unsigned PAT_W   = 4;
  localparam int unsigned PRIME_W = 3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             DIR_UP   = 1'b0;
  localparam logic             DIR_DN   = 1'b1;

  typedef enum logic [1:0] {
    MODE_CHASE  = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  // Tick synchroniser, edge-history flop and post-reset prime delay
  logic               tick_s1;
  logic               tick_s2;
  logic               tick_s3;
  logic [PRIME_W-1:0] prime_sr;
  logic               primed;
  logic               step;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      tick_s1  <= 1'b0;
      tick_s2  <= 1'b0;
      tick_s3  <= 1'b0;
      prime_sr <= '0;
    end else begin
      tick_s1  <= bus.i_Tick;
      tick_s2  <= tick_s1;
      tick_s3  <= tick_s2;
      prime_sr <= {prime_sr[PRIME_W-2:0], 1'b1};
    end
  end

  // primed rises on the 3rd clock after release, masking a tick held high through reset
  assign primed = prime_sr[PRIME_W-1];
  assign step   = primed & (tick_s2 ^ tick_s3);

  // Button synchroniser and debounce window
  logic             sw_s1;
  logic             b_sync;
  logic             b_db;
  logic             b_db_q;
  logic [CNT_W-1:0] cnt;
  logic             press;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sw_s1  <= 1'b0;
      b_sync <= 1'b0;
      b_db   <= 1'b0;
      b_db_q <= 1'b0;
      cnt    <= '0;
    end else begin
      sw_s1  <= bus.i_Switch_1;
      b_sync <= sw_s1;
      b_db_q <= b_db;
      if (b_sync == b_db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        b_db <= b_sync;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Rising edge of the debounced level only
  assign press = b_db & ~b_db_q;

  // Mode / pattern state register
  mode_e            mode;
  mode_e            mode_nxt;
  logic [PAT_W-1:0] pat;
  logic [PAT_W-1:0] pat_nxt;
  logic             dir;
  logic             dir_nxt;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      mode <= MODE_CHASE;
      pat  <= PAT_W'(4'b0001);
      dir  <= DIR_UP;
    end else begin
      mode <= mode_nxt;
      pat  <= pat_nxt;
      dir  <= dir_nxt;
    end
  end

  // Next-state: a press reloads the new mode's start pattern and swallows any step
  always_comb begin
    mode_nxt = mode;
    pat_nxt  = pat;
    dir_nxt  = dir;
    if (press) begin
      mode_nxt = mode_e'(mode + 2'd1);
      dir_nxt  = DIR_UP;
      case (mode_nxt)
        MODE_CHASE:  pat_nxt = PAT_W'(4'b0001);
        MODE_BOUNCE: pat_nxt = PAT_W'(4'b0001);
        MODE_BLINK:  pat_nxt = PAT_W'(4'b1111);
        MODE_COUNT:  pat_nxt = PAT_W'(4'b0000);
        default:     pat_nxt = PAT_W'(4'b0001);
      endcase
    end else if (step) begin
      case (mode)
        MODE_CHASE: pat_nxt = {pat[PAT_W-2:0], pat[PAT_W-1]};
        MODE_BOUNCE: begin
          // Direction flips on reaching an endpoint so each end is shown once
          if (dir == DIR_UP) begin
            pat_nxt = {pat[PAT_W-2:0], 1'b0};
            if (pat_nxt == PAT_W'(4'b1000)) dir_nxt = DIR_DN;
          end else begin
            pat_nxt = {1'b0, pat[PAT_W-1:1]};
            if (pat_nxt == PAT_W'(4'b0001)) dir_nxt = DIR_UP;
          end
        end
        MODE_BLINK: pat_nxt = ~pat;
        MODE_COUNT: pat_nxt = pat + PAT_W'(1);
        default:    pat_nxt = pat;
      endcase
    end
  end

  // LEDs are the pattern flops themselves
  always_comb begin
    bus.o_LED_1 = pat[0];
    bus.o_LED_2 = pat[1];
    bus.o_LED_3 = pat[2];
    bus.o_LED_4 = pat[3];
  end

endmodule
